// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared constants, opcodes and CRC-4 helper for the mtm_Alu serial front end
package mtm_alu_pkg;

    localparam int FRAME_BITS = 11;

    localparam logic IND_DATA = 1'b0;
    localparam logic IND_CMD  = 1'b1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_t;

    // Bit positions inside err_flags_o = {ERR_DATA, ERR_CRC, ERR_OP}
    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    // Galois LFSR x^4+x+1, init 0, message consumed MSB first
    function automatic logic [3:0] crc4_68(input logic [67:0] d);
        logic [3:0] crc;
        logic       fb;
        crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ d[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// rtl/mtm_alu_frame_rx.sv - start-bit detect and frame capture; flags the stop-bit cycle to the packet FSM
module mtm_alu_frame_rx #(
    parameter int FRAME_BITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       frame_valid,
    output logic       frame_type,
    output logic [7:0] frame_byte,
    output logic       frame_err
);
    import mtm_alu_pkg::*;

    typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;

    localparam int              CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] STOP_IDX = CNT_W'(FRAME_BITS - 2);

    rx_state_t               state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-3:0]   shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (state == RX_IDLE) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                // Stop bit is judged live on sin, never stored
                if (bit_cnt != STOP_IDX)
                    shreg <= {shreg[FRAME_BITS-4:0], sin};
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_valid = 1'b0;
        case (state)
            RX_IDLE: if (!sin) state_nxt = RX_BITS;
            RX_BITS: begin
                if (bit_cnt == STOP_IDX) begin
                    frame_valid = 1'b1;
                    state_nxt   = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign frame_type = shreg[FRAME_BITS-3];
    assign frame_byte = shreg[7:0];
    assign frame_err  = ~sin;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - packet assembly, CRC/opcode checking and result pulses for mtm_Alu
module mtm_alu_deserializer #(
    parameter int DATA_FRAMES = 8,
    parameter int FRAME_BITS  = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  op_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [2:0]  err_flags_o
);
    import mtm_alu_pkg::*;

    localparam int               CNT_W = $clog2(DATA_FRAMES + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_FRAMES);

    logic             frame_valid, frame_type, frame_err;
    logic [7:0]       frame_byte;
    logic [CNT_W-1:0] data_cnt;
    logic             overflow;
    logic [63:0]      data_sh;
    logic [2:0]       cmd_op;
    logic             data_ok, crc_ok, op_ok;

    mtm_alu_frame_rx #(.FRAME_BITS(FRAME_BITS)) u_frame_rx (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .frame_byte  (frame_byte),
        .frame_err   (frame_err)
    );

    // data_sh ends up as {B, A}: first byte received lands in B[31:24]
    assign cmd_op  = frame_byte[6:4];
    assign data_ok = (data_cnt == FULL) && !overflow;
    assign crc_ok  = crc4_68({data_sh, 1'b1, cmd_op}) == frame_byte[3:0];
    assign op_ok   = cmd_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};

    always_ff @(posedge clk) begin
        if (rst) begin
            data_cnt    <= '0;
            overflow    <= 1'b0;
            data_sh     <= '0;
            a_o         <= '0;
            b_o         <= '0;
            op_o        <= '0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= '0;
        end else begin
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= '0;
            if (frame_valid) begin
                if (frame_err) begin
                    overflow <= 1'b1;
                end else if (frame_type == IND_DATA) begin
                    if (data_cnt < FULL) begin
                        data_sh  <= {data_sh[55:0], frame_byte};
                        data_cnt <= data_cnt + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    data_cnt <= '0;
                    overflow <= 1'b0;
                    if (!data_ok) begin
                        err_o                 <= 1'b1;
                        err_flags_o[ERR_DATA] <= 1'b1;
                    end else if (!crc_ok) begin
                        err_o                <= 1'b1;
                        err_flags_o[ERR_CRC] <= 1'b1;
                    end else if (!op_ok) begin
                        err_o               <= 1'b1;
                        err_flags_o[ERR_OP] <= 1'b1;
                    end else begin
                        valid_o <= 1'b1;
                        b_o     <= data_sh[63:32];
                        a_o     <= data_sh[31:0];
                        op_o    <= cmd_op;
                    end
                end
            end
        end
    end

endmodule
